instr_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the single-cycle GPR/SGPR/flag datapath. It fetches 32-bit instructions from an instruction memory over a req/ack handshake and holds each one in the instruction register driven into the datapath. It issues a one-cycle commit strobe per instruction and advances the program counter. It also inserts extra wait cycles for multiply, stops on a halt opcode or an illegal opcode, and honours a stop request at instruction boundaries.

---
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/commit control for the
// single-cycle GPR/SGPR/flag datapath. Holds the fetched word in ir and
// gives the datapath one commit strobe (exec_en) per instruction.
module instr_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int MUL_LAT    = 2,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       retired
);
    // The wait counter only ever holds MUL_LAT-1 down to 0.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [4:0] OP_MUL  = 5'h04;
    localparam logic [4:0] OP_LAST = 5'h0B;  // highest legal datapath op
    localparam logic [4:0] OP_HALT = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_EXEC, S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wcnt;
    logic             stop_pend;
    logic             launch;     // start accepted this cycle
    logic [4:0]       opcode;
    logic             op_illegal;

    assign opcode     = ir[31:27];
    assign op_illegal = (opcode > OP_LAST) && (opcode != OP_HALT);
    assign imem_addr  = pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        imem_req  = 1'b0;
        exec_en   = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                busy = 1'b1;
                if (opcode == OP_HALT || op_illegal)      state_nxt = S_HALT;
                else if (opcode == OP_MUL && MUL_LAT > 0) state_nxt = S_WAIT;
                else                                      state_nxt = S_EXEC;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wcnt == '0) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                exec_en   = 1'b1;
                state_nxt = (stop || stop_pend) ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Instruction register: only the fetch-ack edge writes it, so the
    // datapath sees a stable word from DECODE through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            ir <= '0;
        else if (state == S_FETCH && imem_ack) ir <= imem_rdata;
    end

    // Program counter and retired count; both move on the edge leaving EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            retired <= '0;
        end else if (launch) begin
            pc      <= ADDR_W'(START_ADDR);
            retired <= '0;
        end else if (state == S_EXEC) begin
            pc <= pc + 1'b1;
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
        end
    end

    // Error flag, stop request latch and mul wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            stop_pend <= 1'b0;
            wcnt      <= '0;
        end else begin
            if (launch)                              err <= 1'b0;
            else if (state == S_DECODE && op_illegal) err <= 1'b1;

            if (launch || state == S_EXEC) stop_pend <= 1'b0;
            else if (stop && busy)         stop_pend <= 1'b1;

            if (state == S_DECODE && opcode == OP_MUL && MUL_LAT > 0)
                wcnt <= CNT_W'(MUL_LAT - 1);
            else if (state == S_WAIT && wcnt != '0)
                wcnt <= wcnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a responding instruction memory pushes each
// legal fetched word onto a scoreboard, a monitor pops it on exec_en.
module tb_instr_sequencer;
    localparam int ADDR_W  = 8;
    localparam int MUL_LAT = 2;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              imem_req, exec_en, busy, halted, err;
    logic [ADDR_W-1:0] imem_addr, pc;
    logic [31:0]       ir;
    logic [15:0]       retired;

    // narrow-PC instance for the wrap scenario; memory always acks an add
    logic        w_start = 1'b0, w_stop = 1'b0;
    logic        w_req, w_ack, w_exec, w_busy, w_halted, w_err;
    logic [1:0]  w_addr, w_pc;
    logic [31:0] w_ir;
    logic [15:0] w_retired;
    localparam logic [31:0] W_ADD = {5'h02, 27'h1};
    assign w_ack = w_req;

    instr_sequencer #(.ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT), .START_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .exec_en(exec_en), .pc(pc),
        .busy(busy), .halted(halted), .err(err), .retired(retired));

    instr_sequencer #(.ADDR_W(2), .MUL_LAT(MUL_LAT), .START_ADDR(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(w_start), .stop(w_stop),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
        .imem_rdata(W_ADD), .ir(w_ir), .exec_en(w_exec), .pc(w_pc),
        .busy(w_busy), .halted(w_halted), .err(w_err), .retired(w_retired));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       ir;
    } commit_t;

    logic [31:0] mem [256];
    commit_t     sb [$];
    commit_t     exp_c;
    int          ack_delay = 0, mem_wait = 0;
    int          checks = 0, errors = 0;
    logic        exec_prev = 1'b0;

    function automatic logic [31:0] ins(input logic [4:0] op, input int tag);
        return {op, 27'(tag)};
    endfunction

    // Instruction memory: ack after ack_delay wait cycles; legal ops are
    // expected to commit later at the same pc with the same ir.
    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            if (mem_wait >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                mem_wait   = 0;
                if (imem_rdata[31:27] <= 5'h0B)
                    sb.push_back('{pc: imem_addr, ir: imem_rdata});
            end else begin
                imem_ack = 1'b0;
                mem_wait++;
            end
        end else begin
            imem_ack = 1'b0;
            mem_wait = 0;
        end
    end

    // Commit monitor.
    always @(negedge clk) begin
        if (rst_n && exec_en) begin
            checks++;
            if (exec_prev) begin
                errors++;
                $display("FAIL exec_consecutive: exec_en high two cycles running at pc=%0h", pc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_exec: pc=%0h ir=%h, no commit expected", pc, ir);
            end else begin
                exp_c = sb.pop_front();
                if ({pc, ir} !== {exp_c.pc, exp_c.ir}) begin
                    errors++;
                    $display("FAIL sb_commit: got pc=%0h ir=%h, expected pc=%0h ir=%h",
                             pc, ir, exp_c.pc, exp_c.ir);
                end
            end
        end
        exec_prev = exec_en;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, exec_en, busy, halted, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {imem_req, exec_en, busy, halted, err});
        end
        checks++;
        if ({pc, imem_addr, ir, retired} !== '0) begin
            errors++;
            $display("FAIL reset_regs: pc=%0h addr=%0h ir=%h retired=%0d, expected all 0",
                     pc, imem_addr, ir, retired);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, imem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy/req=%b, expected 00", {busy, imem_req});
        end
    endtask

    task automatic test_basic();
        logic [15:0] mask = '0;
        mem[0] = ins(5'h02, 1);
        mem[1] = ins(5'h02, 2);
        mem[2] = ins(5'h1F, 3);
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (exec_en) mask[c] = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (mask !== 16'h0048) begin
            errors++;
            $display("FAIL basic_exec_cycles: got %h, expected 0048", mask);
        end
        checks++;
        if ({halted, err, busy, pc, retired} !== {1'b1, 1'b0, 1'b0, 8'd2, 16'd2}) begin
            errors++;
            $display("FAIL basic_end: halted=%b err=%b busy=%b pc=%0d retired=%0d, expected 1 0 0 2 2",
                     halted, err, busy, pc, retired);
        end
    endtask

    task automatic test_mul();
        logic [15:0] em = '0, rm = '0, bm = '0;
        mem[0] = ins(5'h04, 5);
        mem[1] = ins(5'h1F, 6);
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            em[c] = exec_en;
            rm[c] = imem_req;
            bm[c] = busy;
            @(negedge clk);
        end
        checks++;
        if ({em, rm, bm} !== {16'h0020, 16'h0042, 16'h00FE}) begin
            errors++;
            $display("FAIL mul_timing: exec=%h req=%h busy=%h, expected 0020 0042 00fe", em, rm, bm);
        end
        checks++;
        if ({halted, pc, retired} !== {1'b1, 8'd1, 16'd1}) begin
            errors++;
            $display("FAIL mul_end: halted=%b pc=%0d retired=%0d, expected 1 1 1", halted, pc, retired);
        end
    endtask

    task automatic test_fetch_wait();
        ack_delay = 4;
        mem[0] = ins(5'h02, 7);
        mem[1] = ins(5'h1F, 8);
        pulse_start();
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if ({imem_req, imem_addr, ir} !== {1'b1, 8'd0, ins(5'h1F, 6)}) begin
                errors++;
                $display("FAIL fetch_hold c%0d: req=%b addr=%0h ir=%h, expected 1 0 %h",
                         c, imem_req, imem_addr, ir, ins(5'h1F, 6));
            end
            @(negedge clk);
        end
        checks++;
        if ({imem_req, ir} !== {1'b0, ins(5'h02, 7)}) begin
            errors++;
            $display("FAIL fetch_ack: req=%b ir=%h, expected 0 %h", imem_req, ir, ins(5'h02, 7));
        end
        for (int i = 0; i < 30 && !halted; i++) @(negedge clk);
        checks++;
        if ({halted, retired} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL fetch_end: halted=%b retired=%0d, expected 1 1", halted, retired);
        end
        ack_delay = 0;
    endtask

    task automatic test_illegal();
        mem[0] = ins(5'h02, 9);
        mem[1] = ins(5'h15, 10);
        pulse_start();
        for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
        checks++;
        if ({halted, err, pc, retired, ir} !== {1'b1, 1'b1, 8'd1, 16'd1, ins(5'h15, 10)}) begin
            errors++;
            $display("FAIL illegal_halt: halted=%b err=%b pc=%0d retired=%0d ir=%h, expected 1 1 1 1 %h",
                     halted, err, pc, retired, ir, ins(5'h15, 10));
        end
        mem[0] = ins(5'h1F, 11);
        pulse_start();
        checks++;
        if ({err, halted, busy, pc, retired} !== {1'b0, 1'b0, 1'b1, 8'd0, 16'd0}) begin
            errors++;
            $display("FAIL illegal_restart: err=%b halted=%b busy=%b pc=%0d retired=%0d, expected 0 0 1 0 0",
                     err, halted, busy, pc, retired);
        end
        for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
        checks++;
        if ({halted, err, pc} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL halt_op: halted=%b err=%b pc=%0d, expected 1 0 0", halted, err, pc);
        end
    endtask

    task automatic test_stop();
        logic any_req = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = ins(5'h02, 20 + i);
        pulse_start();
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 8'd5); i++) @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'd5}) begin
            errors++;
            $display("FAIL stop_reach_pc5: req=%b addr=%0h, expected 1 5", imem_req, imem_addr);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        checks++;
        if ({busy, halted, pc, retired} !== {1'b0, 1'b0, 8'd6, 16'd6}) begin
            errors++;
            $display("FAIL stop_idle: busy=%b halted=%b pc=%0d retired=%0d, expected 0 0 6 6",
                     busy, halted, pc, retired);
        end
        for (int i = 0; i < 4; i++) begin
            any_req |= imem_req;
            @(negedge clk);
        end
        checks++;
        if (any_req !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_fetch: imem_req=%b after stop, expected 0", any_req);
        end
        // start and stop together from IDLE: start wins, stop then ends it
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, imem_req, imem_addr} !== {1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL start_wins: busy=%b req=%b addr=%0h, expected 1 1 0", busy, imem_req, imem_addr);
        end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({busy, pc, retired} !== {1'b0, 8'd1, 16'd1}) begin
            errors++;
            $display("FAIL start_stop_end: busy=%b pc=%0d retired=%0d, expected 0 1 1", busy, pc, retired);
        end
    endtask

    task automatic test_reset_mid();
        mem[0] = ins(5'h04, 30);
        pulse_start();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, imem_req, exec_en} !== 3'b100) begin
            errors++;
            $display("FAIL mid_in_wait: busy/req/exec=%b, expected 100", {busy, imem_req, exec_en});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, exec_en, busy, halted, err, pc, ir, retired} !== '0) begin
            errors++;
            $display("FAIL mid_reset: req=%b exec=%b busy=%b halted=%b err=%b pc=%0h ir=%h retired=%0d, expected all 0",
                     imem_req, exec_en, busy, halted, err, pc, ir, retired);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, imem_req, retired} !== '0) begin
            errors++;
            $display("FAIL mid_after: busy=%b req=%b retired=%0d, expected 0 0 0", busy, imem_req, retired);
        end
    endtask

    task automatic test_wrap();
        int cnt = 0;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (w_exec) cnt++;
        end
        checks++;
        if ({cnt[2:0], w_pc} !== {3'd4, 2'd3}) begin
            errors++;
            $display("FAIL wrap_fourth: execs=%0d pc=%0d, expected 4 3", cnt, w_pc);
        end
        @(negedge clk);
        checks++;
        if ({w_pc, w_req, w_addr} !== {2'd0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL wrap_refetch: pc=%0d req=%b addr=%0d, expected 0 1 0", w_pc, w_req, w_addr);
        end
        w_stop = 1'b1;
        for (int i = 0; i < 10 && w_busy; i++) @(negedge clk);
        w_stop = 1'b0;
        checks++;
        if ({w_busy, w_halted, w_err, w_pc, w_retired, w_ir} !== {3'b000, 2'd1, 16'd5, W_ADD}) begin
            errors++;
            $display("FAIL wrap_stop: busy=%b halted=%b err=%b pc=%0d retired=%0d ir=%h, expected 0 0 0 1 5 %h",
                     w_busy, w_halted, w_err, w_pc, w_retired, w_ir, W_ADD);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ins(5'h1F, 100 + i);
        test_reset();
        test_basic();
        test_mul();
        test_fetch_wait();
        test_illegal();
        test_stop();
        test_reset_mid();
        test_wrap();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d commits never seen, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
